// File: rtl/spi_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
//
// Receive side of an SPI link. The asynchronous sclk / CS / MOSI pins are
// resynchronised into the clk domain. MSB-first frames of DATA_WIDTH bits are
// deserialised, and each word is offered on a valid/ready port backed by a
// one-entry holding register. A word that arrives while the holding register
// is still occupied is dropped, and the sticky overrun flag is raised.
//
// Parameters
//   DATA_WIDTH   bits per SPI frame (>= 2)
//   SYNC_STAGES  flop stages per pin synchroniser (>= 2)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   sclk       in   SPI clock from master (async to clk)
//   CS         in   chip select, active-low (async to clk)
//   MOSI       in   serial data, sampled on sclk rising edge
//   rx_ready   in   downstream accepts rx_data
//   clr_ovr    in   single-cycle pulse clearing overrun
//   rx_data    out  received word
//   rx_valid   out  rx_data holds an unconsumed word
//   busy       out  frame in progress (FSM not IDLE)
//   overrun    out  sticky: at least one word dropped
//   frame_err  out  one-cycle pulse on a truncated frame
//                   (present only when SPI_RX_FRAME_ERR_EN is defined)
//
// Build option: define SPI_RX_FRAME_ERR_EN to add the frame_err output.
// -----------------------------------------------------------------------------
module spi_slave_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  CS,
  input  logic                  MOSI,
  input  logic                  rx_ready,
  input  logic                  clr_ovr,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  overrun
`ifdef SPI_RX_FRAME_ERR_EN
  ,
  output logic                  frame_err
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    LOAD = 2'd2
  } state_t;

  // Synchroniser chains; index 0 samples the pin.
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_q,      sclk_d;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise_s;

  state_t                  state_q,    state_d;
  logic [CNT_W-1:0]        cnt_q,      cnt_d;
  logic [DATA_WIDTH-1:0]   shreg_q,    shreg_d;
  logic [DATA_WIDTH-1:0]   rx_data_q,  rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    busy_q,     busy_d;
  logic                    overrun_q,  overrun_d;
  logic                    drop_s;
`ifdef SPI_RX_FRAME_ERR_EN
  logic                    frame_err_q, frame_err_d;
`endif

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_q;

  // Next values of the synchroniser chains and the sclk edge-detect flop.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   CS};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sclk_d      = sclk_s;
  end

  // Receive FSM, shift register, holding register and overrun flag.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    // A transfer at this edge empties the holding register; LOAD may refill it.
    rx_valid_d = rx_valid_q & ~rx_ready;
    drop_s     = 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
    frame_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!cs_s) begin
          state_d = RECV;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = IDLE;
        end
      end

      RECV: begin
        if (cs_s) begin
          // Deselect mid-frame: the partial word is thrown away.
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
`ifdef SPI_RX_FRAME_ERR_EN
          frame_err_d = (cnt_q != CNT_ZERO);
`endif
        end else if (sclk_rise_s) begin
          shreg_d = {shreg_q[DATA_WIDTH-2:0], mosi_s};
          if (cnt_q == CNT_LAST) begin
            state_d = LOAD;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = RECV;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = RECV;
        end
      end

      LOAD: begin
        // shreg_q holds the complete word during this single cycle.
        if (!rx_valid_q || rx_ready) begin
          rx_data_d  = shreg_q;
          rx_valid_d = 1'b1;
        end else begin
          drop_s = 1'b1;
        end

        if (cs_s) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = RECV;
          // A rise already here is bit 0 of the following frame.
          if (sclk_rise_s) begin
            shreg_d = {shreg_q[DATA_WIDTH-2:0], mosi_s};
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d   = CNT_ZERO;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // Set has priority over clear.
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    busy_d = (state_d != IDLE);
  end

  // State registers; synchronisers reset to idle line levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      sclk_q      <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      shreg_q     <= {DATA_WIDTH{1'b0}};
      rx_data_q   <= {DATA_WIDTH{1'b0}};
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_q      <= sclk_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef SPI_RX_FRAME_ERR_EN
  // Truncated-frame pulse register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`endif

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_rx
//
// Drives SPI frames at clk/8 and keeps a queue of the words that should
// reach the output port. The holding-register rule is modelled directly: a
// completed word is kept if no earlier word is still waiting, or if
// downstream is ready when the word lands; otherwise it is dropped and
// overrun is expected. A monitor pops the queue on every handshake.
// -----------------------------------------------------------------------------
module tb_spi_slave_rx;

  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          sclk;
  logic          cs;
  logic          mosi;
  logic          rx_ready;
  logic          clr_ovr;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          busy;
  logic          overrun;
`ifdef SPI_RX_FRAME_ERR_EN
  logic          frame_err;
`endif

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] sb_q[$];
  int            cyc = 0;
  int            last_rise_cyc = 0;
  int            valid_rise_cyc = -1;
  logic          prev_valid = 1'b0;
  int            ferr_cnt = 0;
  int            exp_ferr = 0;
  logic          exp_ovr = 1'b0;

  spi_slave_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .CS       (cs),
    .MOSI     (mosi),
    .rx_ready (rx_ready),
    .clr_ovr  (clr_ovr),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .overrun  (overrun)
`ifdef SPI_RX_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen here completes on the next rising edge.
  initial begin
    logic [DW-1:0] exp_w;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
        prev_valid = rx_valid;
        if (rx_valid && rx_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_word actual=0x%0h required=none", rx_data);
          end else begin
            exp_w = sb_q.pop_front();
            chk("word", {24'h0, rx_data}, {24'h0, exp_w});
          end
        end
`ifdef SPI_RX_FRAME_ERR_EN
        if (frame_err) ferr_cnt++;
`endif
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sclk = 1'b0;
    mosi = b;
    step(4);
    sclk = 1'b1;
    last_rise_cyc = cyc;
    step(4);
  endtask

  task automatic start_frame();
    cs = 1'b0;
    step(3);
  endtask

  task automatic end_frame();
    sclk = 1'b0;
    step(4);
    cs = 1'b1;
    step(6);
  endtask

  // collide: raise rx_ready only for the cycle in which the word lands.
  task automatic send_frame(input logic [DW-1:0] w, input int nbits, input logic collide);
    logic accept;
    accept = (sb_q.size() == 0) || rx_ready || collide;
    if (nbits == DW) begin
      if (accept) sb_q.push_back(w);
      else exp_ovr = 1'b1;
    end
    for (int i = 0; i < nbits; i++) begin
      if (collide && i == DW - 1) begin
        sclk = 1'b0;
        mosi = w[DW-1-i];
        step(4);
        sclk = 1'b1;
        step(3);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
      end else begin
        send_bit(w[DW-1-i]);
      end
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) step(1);
    chk(name, sb_q.size(), 0);
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    rx_ready = 1'b0; clr_ovr = 1'b0;
    #1 rst = 1'b0;
    step(3);
    chk("rst_data",     {24'h0, rx_data}, 32'h0);
    chk("rst_valid",    rx_valid, 1'b0);
    chk("rst_busy",     busy, 1'b0);
    chk("rst_overrun",  overrun, 1'b0);
    rst = 1'b1;
    step(3);

    // Single frame with latency check.
    rx_ready = 1'b1;
    start_frame();
    chk("busy_in_frame", busy, 1'b1);
    send_frame(8'hA3, DW, 1'b0);
    end_frame();
    chk("latency", valid_rise_cyc - last_rise_cyc, SS + 2);
    wait_drain("drain_single");
    chk("single_overrun", overrun, 1'b0);
    chk("busy_after_cs", busy, 1'b0);

    // Back-to-back frames under one CS.
    start_frame();
    send_frame(8'hA3, DW, 1'b0);
    send_frame(8'h5C, DW, 1'b0);
    send_frame(8'hFF, DW, 1'b0);
    end_frame();
    wait_drain("drain_b2b");

    // Truncated frame followed by a full one.
    start_frame();
    send_frame(8'hA3, 5, 1'b0);
    end_frame();
    exp_ferr++;
    start_frame();
    send_frame(8'h3C, DW, 1'b0);
    end_frame();
    wait_drain("drain_trunc");
`ifdef SPI_RX_FRAME_ERR_EN
    chk("frame_err_pulses", ferr_cnt, exp_ferr);
`endif

    // Backpressure and overrun.
    rx_ready = 1'b0;
    start_frame();
    send_frame(8'h11, DW, 1'b0);
    send_frame(8'h22, DW, 1'b0);
    end_frame();
    chk("bp_valid",   rx_valid, 1'b1);
    chk("bp_data",    {24'h0, rx_data}, 32'h11);
    chk("bp_overrun", overrun, exp_ovr);
    rx_ready = 1'b1;
    wait_drain("drain_bp");
    rx_ready = 1'b0;
    chk("ovr_sticky", overrun, exp_ovr);
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    exp_ovr = 1'b0;
    chk("ovr_cleared", overrun, exp_ovr);

    // Handshake in the same cycle as LOAD.
    start_frame();
    send_frame(8'h01, DW, 1'b0);
    send_frame(8'h02, DW, 1'b1);
    end_frame();
    chk("coll_valid",   rx_valid, 1'b1);
    chk("coll_data",    {24'h0, rx_data}, 32'h02);
    chk("coll_overrun", overrun, exp_ovr);
    rx_ready = 1'b1;
    wait_drain("drain_coll");

    // Reset in the middle of a frame.
    start_frame();
    send_frame(8'hC5, 4, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_data",    {24'h0, rx_data}, 32'h0);
    chk("mid_rst_valid",   rx_valid, 1'b0);
    chk("mid_rst_busy",    busy, 1'b0);
    chk("mid_rst_overrun", overrun, 1'b0);
    sclk = 1'b0;
    cs = 1'b1;
    step(3);
    rst = 1'b1;
    step(4);
    start_frame();
    send_frame(8'hC5, DW, 1'b0);
    end_frame();
    wait_drain("drain_after_rst");
    chk("data_after_rst", {24'h0, rx_data}, 32'hC5);

    // Random words, random downstream readiness, random CS gaps.
    start_frame();
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) rx_ready = 1'($urandom_range(0, 1));
      r = $urandom;
      send_frame(r[DW-1:0], DW, 1'b0);
      if ($urandom_range(0, 4) == 0) begin
        end_frame();
        start_frame();
      end
    end
    end_frame();
    rx_ready = 1'b1;
    wait_drain("drain_rand");
    chk("rand_overrun", overrun, exp_ovr);
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    step(4);
    chk("final_sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
